cfg_loader: RTL and testbench
=============================

# cfg_loader

Bitstream loader and readback verifier for the tinyFPGA configuration chain. It accepts configuration bytes from a host over a valid/ready stream and drives the chain's programming pins: `cfg_en` maps to `prog_en` and `cfg_data` maps to the chain data input. In verify mode it re-shifts the same image and compares the chain's serial output (`prog_out`, here `cfg_out`) bit-for-bit. It sits between the host/test harness and the `io_in`/`io_out` pins of the fabric.

## Interface
- `CHAIN_LEN`, default 128: number of configuration bits in the chain; must be ≥ 1 and may be any value, including values that are not a multiple of 8.
- `IDX_W`, default `$clog2(CHAIN_LEN)`: width of the bit index.
- `clk` in 1: single clock, shared with the chain.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begins a pass; sampled only in IDLE.
- `verify` in 1: sampled with `start`; 0 selects load, 1 selects verify.
- `s_data` in 8: configuration byte, shifted MSB first.
- `s_valid` in 1: host byte valid.
- `s_ready` out 1: loader ready for a byte.
- `cfg_en` out 1: chain shift enable (registered).
- `cfg_data` out 1: chain serial data in (registered).
- `cfg_out` in 1: chain serial data out, taken from the last stage.
- `busy` out 1: high in FETCH and SHIFT.
- `done` out 1: one-cycle pulse at the end of a pass.
- `error` out 1: sticky verify mismatch flag; cleared by an accepted `start`.
- `mismatch_cnt` out 16: number of mismatching bits; saturates at 0xFFFF; cleared by an accepted `start`.
- `first_err_idx` out IDX_W: bit index of the first mismatch; cleared by an accepted `start`.

## Operation
- FSM states are IDLE, FETCH and SHIFT.
- **IDLE**
  - On `start`=1, latch `verify`, clear the bit counter, `error`, `mismatch_cnt` and `first_err_idx`, then go to FETCH.
  - `start` in any other state is ignored.
- **FETCH**
  - `s_ready`=1.
  - On `s_valid`&`s_ready`, load `s_data` into the shift register and go to SHIFT.
  - `cfg_en`=0 while in FETCH, so the chain holds.
- **SHIFT**
  - Each cycle, `cfg_en`=1 and `cfg_data`=the current MSB of the shift register; shift left and increment the bit counter.
  - After the 8th bit of a byte, go to FETCH.
  - After bit CHAIN_LEN−1, go to IDLE and pulse `done`.
- **Bit order**
  - Bit index k=0 is the MSB of the first byte.
  - Final partial byte: only its top (CHAIN_LEN mod 8) bits are shifted; the remaining low bits are discarded.
- **Chain model**: the chain shifts on a `clk` rising edge when `cfg_en`=1. `cfg_out` is the last-stage register, so the first bit shifted in appears on `cfg_out` after CHAIN_LEN shifts.
- **Verify compare**
  - On every edge with `cfg_en`=1 in a verify pass, compare `cfg_out` to `cfg_data`. Both present bit k, because a loaded chain emits the image in the same order.
  - On a mismatch: set `error`, increment `mismatch_cnt` (saturating), and capture k into `first_err_idx` only if this is the first mismatch.
- In a load pass, no comparison is made and `error` stays 0.
- The host must supply the identical byte stream for the verify pass.

## Timing
- **Reset values**: state=IDLE; `s_ready`, `cfg_en`, `cfg_data`, `busy`, `done`, `error`=0; `mismatch_cnt`=0; `first_err_idx`=0.
- **Reset mid-pass**:
  - Outputs drop immediately (asynchronously).
  - No `done` pulse is issued.
  - Chain contents are undefined; the host must reload.
- **Latency**:
  - `start` at edge 0 gives `s_ready`=1 in cycle 1.
  - A byte accepted at edge n gives `cfg_en`=1 from cycle n+1 through n+8.
  - At least one FETCH cycle separates bytes, so the best case is 9 cycles per byte.
- **Stalls**:
  - A `s_valid`=0 stall holds FETCH indefinitely with `cfg_en`=0.
  - `s_data` is ignored while `s_ready`=0.
- **End of pass**:
  - `done`=1 for exactly the cycle after the final shift, coincident with the return to IDLE. A `start` in that cycle is accepted.
  - The final compare result is visible in that same cycle.
- `busy` falls in the same cycle that `done` rises.
- **CHAIN_LEN=1**: one fetch, one shift, then `done`.

## Test plan
- **Reset**: assert `rst_n`=0 mid-test → all outputs at their reset values within the same cycle; `s_ready`=0 until a `start`.
- **Load, CHAIN_LEN=16**: send 0xA5, 0x3C → `cfg_data` under `cfg_en` is 1010_0101_0011_1100; `done` pulses once after the 16th shift; the chain model holds 0xA53C; `error`=0.
- **Verify pass**: verify the same 0xA5, 0x3C after the load → `error`=0, `mismatch_cnt`=0, `done` pulses once.
- **Corrupt verify**: verify with 0xA5, 0x3D against the loaded 0xA53C → `error`=1, `mismatch_cnt`=1, `first_err_idx`=15.
- **Partial byte, CHAIN_LEN=12**: send 0xFF, 0xA0 → exactly 12 `cfg_en` cycles with data 1111_1111_1010; `done` follows; `s_ready` is never raised a third time.
- **Stall, ignored start, reset**:
  - Hold `s_valid`=0 for 5 cycles → `cfg_en`=0 throughout the stall.
  - Pulse `start` during SHIFT → ignored.
  - Drop `rst_n` after the 5th shift → IDLE with `cfg_en`=0 immediately.
  - A new `start` afterwards → accepted.

Source files
------------

// File: rtl/cfg_loader.sv
// cfg_loader
// Streams a configuration image from a host into the tinyFPGA configuration
// chain. In verify mode it re-shifts the same image and compares the chain's
// serial output with the bit being shifted in.
//
// Ports
//   clk, rst_n       : clock shared with the chain; async active-low reset
//   start, verify    : begin a pass (sampled in IDLE only); verify=1 selects readback
//   s_data/s_valid/s_ready : host byte stream, MSB shifted first
//   cfg_en, cfg_data : registered chain shift enable / serial data in
//   cfg_out          : chain serial data out (last stage)
//   busy, done       : pass in progress / one-cycle end-of-pass pulse
//   error, mismatch_cnt, first_err_idx : verify results, cleared by an accepted start
//   state_dbg        : current FSM state for observation
//
// Handshake: a byte transfers on a rising edge where s_valid and s_ready are
// both 1. s_ready depends only on the FSM state (high in FETCH), never on
// s_valid; s_data is don't-care whenever s_ready is 0.
module cfg_loader #(
   parameter int CHAIN_LEN = 128,
   parameter int IDX_W     = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             verify,
   input  logic [7:0]       s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic             cfg_en,
   output logic             cfg_data,
   input  logic             cfg_out,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [15:0]      mismatch_cnt,
   output logic [IDX_W-1:0] first_err_idx,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SHIFT = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHAIN_LEN - 1);

   state_t           state, state_next;
   logic [7:0]       sreg;       // remaining bits of the current byte, MSB next
   logic [IDX_W-1:0] bit_idx;    // chain index of the bit now on cfg_data
   logic [2:0]       byte_bit;   // position of that bit within its byte
   logic             verify_q;
   logic             last_bit;
   logic             byte_end;

   assign last_bit  = (bit_idx == LAST_IDX);
   assign byte_end  = (byte_bit == 3'd7);
   assign state_dbg = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      s_ready    = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_next = FETCH;
         end
         FETCH: begin
            s_ready = 1'b1;
            busy    = 1'b1;
            if (s_valid) state_next = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            // The final partial byte ends the pass early; its low bits are dropped.
            if (last_bit)      state_next = IDLE;
            else if (byte_end) state_next = FETCH;
         end
         default: state_next = IDLE;
      endcase
   end

   // cfg_en/cfg_data are loaded one edge ahead so the chain sees bit k on the
   // edge that retires it; the compare uses the same edge, when cfg_out still
   // holds bit k of the previously loaded image.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg          <= '0;
         bit_idx       <= '0;
         byte_bit      <= '0;
         verify_q      <= 1'b0;
         cfg_en        <= 1'b0;
         cfg_data      <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         mismatch_cnt  <= '0;
         first_err_idx <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  verify_q      <= verify;
                  bit_idx       <= '0;
                  error         <= 1'b0;
                  mismatch_cnt  <= '0;
                  first_err_idx <= '0;
               end
            end
            FETCH: begin
               if (s_valid) begin
                  cfg_en   <= 1'b1;
                  cfg_data <= s_data[7];
                  sreg     <= {s_data[6:0], 1'b0};
                  byte_bit <= '0;
               end
            end
            SHIFT: begin
               if (verify_q && (cfg_out != cfg_data)) begin
                  error <= 1'b1;
                  if (mismatch_cnt != 16'hFFFF) mismatch_cnt <= mismatch_cnt + 16'd1;
                  if (!error) first_err_idx <= bit_idx;
               end
               if (last_bit) begin
                  cfg_en <= 1'b0;
                  done   <= 1'b1;
               end else if (byte_end) begin
                  cfg_en  <= 1'b0;
                  bit_idx <= bit_idx + IDX_W'(1);
               end else begin
                  cfg_data <= sreg[7];
                  sreg     <= {sreg[6:0], 1'b0};
                  bit_idx  <= bit_idx + IDX_W'(1);
                  byte_bit <= byte_bit + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cfg_loader.sv
// Bench for cfg_loader: a 16-bit and a 12-bit chain instance, each with a
// behavioural chain model, sharing reset, verify and the byte stream.
module tb_cfg_loader;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start16, start12, verify, s_valid;
   logic [7:0] s_data;

   logic        s_ready16, cfg_en16, cfg_data16, busy16, done16, error16;
   logic [15:0] mcnt16;
   logic [3:0]  fei16;
   logic [1:0]  st16;
   logic        s_ready12, cfg_en12, cfg_data12, busy12, done12, error12;
   logic [15:0] mcnt12;
   logic [3:0]  fei12;
   logic [1:0]  st12;

   logic [15:0] chain16 = '0;
   logic [11:0] chain12 = '0;

   always @(posedge clk) begin
      if (cfg_en16) chain16 <= {chain16[14:0], cfg_data16};
      if (cfg_en12) chain12 <= {chain12[10:0], cfg_data12};
   end

   cfg_loader #(.CHAIN_LEN(16)) u16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .verify(verify),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready16),
      .cfg_en(cfg_en16), .cfg_data(cfg_data16), .cfg_out(chain16[15]),
      .busy(busy16), .done(done16), .error(error16),
      .mismatch_cnt(mcnt16), .first_err_idx(fei16), .state_dbg(st16)
   );

   cfg_loader #(.CHAIN_LEN(12)) u12 (
      .clk(clk), .rst_n(rst_n), .start(start12), .verify(verify),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready12),
      .cfg_en(cfg_en12), .cfg_data(cfg_data12), .cfg_out(chain12[11]),
      .busy(busy12), .done(done12), .error(error12),
      .mismatch_cnt(mcnt12), .first_err_idx(fei12), .state_dbg(st12)
   );

   // ---------------- scoreboard ----------------
   int vectors     = 0;
   int miscompares = 0;
   logic [0:0] exp_q16[$];
   logic [0:0] exp_q12[$];
   logic [0:0] e16, e12;
   int done_cnt16 = 0, done_cnt12 = 0;
   int shift_cnt16 = 0, shift_cnt12 = 0;
   int ready_rise12 = 0;
   logic ready12_q = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic fail_now(input string tag);
      vectors++;
      miscompares++;
      $error("FAIL %s: observed event did not match expectation", tag);
   endtask

   always @(negedge clk) begin
      if (done16) done_cnt16++;
      if (done12) done_cnt12++;
      if (s_ready12 && !ready12_q) ready_rise12++;
      ready12_q = s_ready12;
      if (cfg_en16) begin
         shift_cnt16++;
         if (exp_q16.size() == 0) fail_now("extra_shift16");
         else begin
            e16 = exp_q16.pop_front();
            check("cfg_data16", 32'(cfg_data16), 32'(e16));
         end
      end
      if (cfg_en12) begin
         shift_cnt12++;
         if (exp_q12.size() == 0) fail_now("extra_shift12");
         else begin
            e12 = exp_q12.pop_front();
            check("cfg_data12", 32'(cfg_data12), 32'(e12));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input bit sel12, input bit vfy);
      if (sel12) start12 = 1'b1; else start16 = 1'b1;
      verify = vfy;
      tick();
      start12 = 1'b0;
      start16 = 1'b0;
      verify  = 1'b0;
   endtask

   task automatic send_byte(input bit sel12, input logic [7:0] b, input int nbits);
      int waited = 0;
      while (!(sel12 ? s_ready12 : s_ready16) && waited < 50) begin
         tick();
         waited++;
      end
      if (waited >= 50) fail_now("ready_timeout");
      s_valid = 1'b1;
      s_data  = b;
      for (int i = 7; i >= 8 - nbits; i--) begin
         if (sel12) exp_q12.push_back(b[i]);
         else       exp_q16.push_back(b[i]);
      end
      tick();
      s_valid = 1'b0;
      s_data  = 8'($urandom_range(0, 255));
      check("en_after_accept", 32'(sel12 ? cfg_en12 : cfg_en16), 32'd1);
   endtask

   task automatic wait_done(input bit sel12);
      int n = 0;
      while (!(sel12 ? done12 : done16) && n < 60) begin
         tick();
         n++;
      end
      if (n >= 60) fail_now("done_timeout");
      else check("busy_at_done", 32'(sel12 ? busy12 : busy16), 32'd0);
   endtask

   // ---------------- directed sequence ----------------
   int base_shift, base_done;

   initial begin
      rst_n = 1'b0; start16 = 1'b0; start12 = 1'b0;
      verify = 1'b0; s_valid = 1'b0; s_data = 8'h00;

      // reset state
      repeat (3) tick();
      check("rst_flags16", 32'({s_ready16, cfg_en16, cfg_data16, busy16, done16, error16}), 32'd0);
      check("rst_mcnt16", 32'(mcnt16), 32'd0);
      check("rst_fei16", 32'(fei16), 32'd0);
      check("rst_state16", 32'(st16), 32'd0);
      rst_n = 1'b1;
      repeat (3) tick();
      check("ready_before_start", 32'(s_ready16), 32'd0);

      // load 0xA5 0x3C into the 16-bit chain
      do_start(1'b0, 1'b0);
      check("ready_in_fetch", 32'(s_ready16), 32'd1);
      check("busy_in_fetch", 32'(busy16), 32'd1);
      send_byte(1'b0, 8'hA5, 8);
      send_byte(1'b0, 8'h3C, 8);
      wait_done(1'b0);
      check("load_error", 32'(error16), 32'd0);
      tick();
      check("done_one_cycle", 32'(done16), 32'd0);
      check("load_chain", 32'(chain16), 32'hA53C);
      check("load_q_empty", 32'(exp_q16.size()), 32'd0);
      check("load_done_cnt", 32'(done_cnt16), 32'd1);

      // verify the same image
      do_start(1'b0, 1'b1);
      send_byte(1'b0, 8'hA5, 8);
      send_byte(1'b0, 8'h3C, 8);
      wait_done(1'b0);
      check("verify_error", 32'(error16), 32'd0);
      check("verify_mcnt", 32'(mcnt16), 32'd0);
      tick();
      check("verify_done_cnt", 32'(done_cnt16), 32'd2);
      check("verify_chain", 32'(chain16), 32'hA53C);

      // corrupt verify: last bit differs
      do_start(1'b0, 1'b1);
      send_byte(1'b0, 8'hA5, 8);
      send_byte(1'b0, 8'h3D, 8);
      wait_done(1'b0);
      check("corrupt_error", 32'(error16), 32'd1);
      check("corrupt_mcnt", 32'(mcnt16), 32'd1);
      check("corrupt_fei", 32'(fei16), 32'd15);
      tick();
      check("corrupt_done_cnt", 32'(done_cnt16), 32'd3);

      // partial final byte on the 12-bit chain
      do_start(1'b1, 1'b0);
      send_byte(1'b1, 8'hFF, 8);
      send_byte(1'b1, 8'hA0, 4);
      wait_done(1'b1);
      check("partial_q_empty", 32'(exp_q12.size()), 32'd0);
      check("partial_shifts", 32'(shift_cnt12), 32'd12);
      repeat (10) tick();
      check("partial_chain", 32'(chain12), 32'hFFA);
      check("partial_ready_rises", 32'(ready_rise12), 32'd2);
      check("partial_done_cnt", 32'(done_cnt12), 32'd1);

      // stall, ignored start, reset mid-pass
      do_start(1'b0, 1'b0);
      check("start_clears_error", 32'(error16), 32'd0);
      check("start_clears_mcnt", 32'(mcnt16), 32'd0);
      check("start_clears_fei", 32'(fei16), 32'd0);
      for (int i = 0; i < 5; i++) begin
         check("stall_en", 32'(cfg_en16), 32'd0);
         check("stall_ready", 32'(s_ready16), 32'd1);
         tick();
      end
      base_shift = shift_cnt16;
      send_byte(1'b0, 8'hC3, 8);
      start16 = 1'b1;
      tick();
      start16 = 1'b0;
      check("ign_start_en", 32'(cfg_en16), 32'd1);
      check("ign_start_busy", 32'(busy16), 32'd1);
      check("ign_start_ready", 32'(s_ready16), 32'd0);
      repeat (4) tick();
      base_done = done_cnt16;
      rst_n = 1'b0;
      #1;
      check("midrst_en", 32'(cfg_en16), 32'd0);
      check("midrst_busy", 32'(busy16), 32'd0);
      check("midrst_ready", 32'(s_ready16), 32'd0);
      check("midrst_state", 32'(st16), 32'd0);
      exp_q16.delete();
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      check("midrst_shifts", 32'(shift_cnt16 - base_shift), 32'd5);
      check("no_done_on_reset", 32'(done_cnt16), 32'(base_done));

      // restart after reset
      do_start(1'b0, 1'b0);
      check("restart_accepted", 32'(s_ready16), 32'd1);
      send_byte(1'b0, 8'hA5, 8);
      send_byte(1'b0, 8'h3C, 8);
      wait_done(1'b0);
      tick();
      check("reload_chain", 32'(chain16), 32'hA53C);
      check("reload_q_empty", 32'(exp_q16.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
